// File: rtl/fproc_meas_responder.sv
// Core-side fproc responder: latches per-channel measurement bits and answers
// each request with a registered data word and a one-cycle fproc_ready pulse.
module fproc_meas_responder #(
    parameter int N_MEAS         = 8,
    parameter int ID_WIDTH       = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ID_WIDTH-1:0]   fproc_id,
    input  logic                  fproc_enable,
    output logic                  fproc_ready,
    output logic [DATA_WIDTH-1:0] fproc_data,
    input  logic [N_MEAS-1:0]     meas,
    input  logic [N_MEAS-1:0]     meas_valid,
    output logic                  busy,
    output logic                  timeout_err
);

    // Handshake: fproc_enable is a one-cycle request strobe accepted only in
    // IDLE; fproc_ready is a one-cycle response strobe with fproc_data valid in
    // that same cycle. Strobes arriving while busy are dropped, not queued.

    localparam int CH_W = ID_WIDTH - 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_RESPOND = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CH_W-1:0]       ch_q, ch_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [N_MEAS-1:0]     lat_q, lat_d;
    logic [N_MEAS-1:0]     fresh_q, fresh_d;
    logic                  terr_q, terr_d;

    logic [CH_W-1:0]   sel_ch;
    logic [N_MEAS-1:0] sel_oh;
    logic              sel_ok, sel_lat, sel_fresh, sel_mv, sel_meas;
    logic              consume;

    function automatic logic [DATA_WIDTH-1:0] pack_resp(
        input logic b, input logic f, input logic inv, input logic to);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        r[0] = b;
        r[1] = f;
        r[2] = inv;
        r[DATA_WIDTH-1] = to;
        return r;
    endfunction

    // In IDLE the channel comes straight from the request; while waiting it is the captured one.
    always_comb begin
        sel_ch = (state_q == S_IDLE) ? fproc_id[CH_W-1:0] : ch_q;
        sel_oh = '0;
        for (int i = 0; i < N_MEAS; i++) begin
            if (sel_ch == CH_W'(i)) sel_oh[i] = 1'b1;
        end
        sel_ok    = |sel_oh;
        sel_lat   = |(lat_q & sel_oh);
        sel_fresh = |(fresh_q & sel_oh);
        sel_mv    = |(meas_valid & sel_oh);
        sel_meas  = |(meas & sel_oh);
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        terr_d  = terr_q;
        consume = 1'b0;
        lat_d   = (lat_q & ~meas_valid) | (meas & meas_valid);
        fresh_d = fresh_q | meas_valid;

        case (state_q)
            S_IDLE: begin
                if (fproc_enable) begin
                    ch_d = fproc_id[CH_W-1:0];
                    if (!sel_ok) begin
                        data_d  = pack_resp(1'b0, 1'b0, 1'b1, 1'b0);
                        state_d = S_RESPOND;
                    end else if (!fproc_id[ID_WIDTH-1] || sel_fresh || sel_mv) begin
                        data_d  = pack_resp(sel_mv ? sel_meas : sel_lat,
                                            sel_fresh | sel_mv, 1'b0, 1'b0);
                        consume = 1'b1;
                        state_d = S_RESPOND;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // A valid on the final wait cycle beats the timeout.
                if (sel_mv) begin
                    data_d  = pack_resp(sel_meas, 1'b1, 1'b0, 1'b0);
                    consume = 1'b1;
                    state_d = S_RESPOND;
                end else if (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    data_d  = pack_resp(sel_lat, sel_fresh, 1'b0, 1'b1);
                    terr_d  = 1'b1;
                    state_d = S_RESPOND;
                end
            end
            S_RESPOND: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        if (consume) fresh_d = fresh_d & ~sel_oh;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            lat_q   <= '0;
            fresh_q <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            lat_q   <= lat_d;
            fresh_q <= fresh_d;
            terr_q  <= terr_d;
        end
    end

    assign fproc_ready = (state_q == S_RESPOND);
    assign busy        = (state_q != S_IDLE);
    assign fproc_data  = data_q;
    assign timeout_err = terr_q;

endmodule

// File: tb/tb_fproc_meas_responder.sv
// Bench for fproc_meas_responder: directed scenarios then randomized requests,
// with expected responses queued by a reference model and checked by a monitor.
module tb_fproc_meas_responder;

    localparam int N  = 8;
    localparam int TO = 16;
    localparam int INF = 32'h7fff_ffff;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  fproc_id = '0;
    logic        fproc_enable = 1'b0;
    logic        fproc_ready;
    logic [31:0] fproc_data;
    logic [N-1:0] meas = '0;
    logic [N-1:0] meas_valid = '0;
    logic        busy;
    logic        timeout_err;

    fproc_meas_responder #(
        .N_MEAS(N), .ID_WIDTH(8), .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TO), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .reset(reset),
        .fproc_id(fproc_id), .fproc_enable(fproc_enable),
        .fproc_ready(fproc_ready), .fproc_data(fproc_data),
        .meas(meas), .meas_valid(meas_valid),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [N-1:0] lat_m = '0;
    logic [N-1:0] fresh_m = '0;
    int terr_set = INF;
    int busy_lo = 1;
    int busy_hi = 0;
    logic [31:0] hold_data = '0;
    bit bg_en = 1'b0;

    logic [31:0] exp_q[$];
    int          cyc_q[$];

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp_v);
        end
    endtask

    // Monitor: pops the scoreboard on every ready pulse, checks status outputs each cycle.
    always @(negedge clk) begin
        logic [31:0] e;
        int ec;
        if (fproc_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", {31'b0, fproc_ready}, 32'h0);
            end else begin
                e  = exp_q.pop_front();
                ec = cyc_q.pop_front();
                check("resp_data", fproc_data, e);
                check("resp_cycle", cyc, ec);
                hold_data = e;
            end
        end else begin
            check("data_hold", fproc_data, hold_data);
        end
        check("busy", {31'b0, busy}, {31'b0, (cyc >= busy_lo && cyc <= busy_hi)});
        check("timeout_err", {31'b0, timeout_err}, {31'b0, (cyc >= terr_set)});
    end

    task automatic drive_bg(input int excl);
        meas = N'($urandom);
        meas_valid = '0;
        if (bg_en) begin
            for (int i = 0; i < N; i++) begin
                if (i != excl && $urandom_range(0, 7) == 0) begin
                    meas_valid[i] = 1'b1;
                    lat_m[i] = meas[i];
                    fresh_m[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            fproc_enable = 1'b0;
            drive_bg(-1);
        end
    endtask

    task automatic pulse_valid(input logic [N-1:0] mv, input logic [N-1:0] mb);
        @(posedge clk); #1;
        fproc_enable = 1'b0;
        meas_valid = mv;
        meas = mb;
        for (int i = 0; i < N; i++) begin
            if (mv[i]) begin
                lat_m[i] = mb[i];
                fresh_m[i] = 1'b1;
            end
        end
    endtask

    // d: cycles after the request at which meas_valid[ch] pulses (-1 = never, 0 = same cycle).
    // spur: cycle offset of an extra strobe that must be ignored (0 = none).
    task automatic request(input logic [7:0] id, input int d, input logic vbit, input int spur);
        int p, ch, ecyc, win;
        logic blk, b;
        logic [31:0] e;
        bit target, consumed;
        @(posedge clk); #1;
        p = cyc + 1;
        ch = {25'b0, id[6:0]};
        blk = id[7];
        target = (ch < N) && (d >= 0);
        consumed = 1'b0;
        if (ch >= N) begin
            e = 32'h4;
            ecyc = p;
        end else if (!blk || fresh_m[ch] || d == 0) begin
            b = (d == 0) ? vbit : lat_m[ch];
            e = {30'b0, fresh_m[ch] | (d == 0), b};
            ecyc = p;
            lat_m[ch] = b;
            fresh_m[ch] = 1'b0;
            consumed = (d == 0);
        end else if (d >= 1 && d <= TO) begin
            e = {30'b0, 1'b1, vbit};
            ecyc = p + d;
            lat_m[ch] = vbit;
            fresh_m[ch] = 1'b0;
            consumed = 1'b1;
        end else begin
            e = 32'h8000_0000 | {31'b0, lat_m[ch]};
            ecyc = p + TO;
            if (ecyc < terr_set) terr_set = ecyc;
        end
        exp_q.push_back(e);
        cyc_q.push_back(ecyc);
        busy_lo = p;
        busy_hi = ecyc;
        win = ecyc - p + 1;
        for (int k = 0; k <= win; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            fproc_enable = (k == 0) || (spur != 0 && k == spur);
            fproc_id = (k == 0) ? id : 8'($urandom);
            drive_bg(ch);
            if (target && k == d) begin
                meas_valid[ch] = 1'b1;
                meas[ch] = vbit;
                if (!consumed) begin
                    lat_m[ch] = vbit;
                    fresh_m[ch] = 1'b1;
                end
            end
        end
    endtask

    initial begin
        repeat (50000) @(posedge clk);
        n_err++;
        $display("FAIL watchdog: got cycle %0d required completion before it", cyc);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] id;
        int chs, d, spur;

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'b0, fproc_ready}, 32'h0);
        check("reset_data", fproc_data, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        reset = 1'b0;

        // Immediate read of a fresh channel, then again once consumed
        pulse_valid(8'h08, 8'h08);
        request(8'h03, -1, 1'b0, 0);
        request(8'h03, -1, 1'b0, 0);
        // Blocking read satisfied by a later valid
        request(8'h85, 10, 1'b1, 0);
        // Blocking read that times out
        request(8'h82, -1, 1'b0, 0);
        // Invalid channel, then ignored strobe during a wait
        request(8'h0A, -1, 1'b0, 0);
        request(8'h84, 5, 1'b0, 2);
        // Same-cycle valid, follow-up shows fresh cleared, valid on the timeout cycle
        request(8'h01, 0, 1'b1, 0);
        request(8'h01, -1, 1'b0, 0);
        request(8'h86, TO, 1'b1, 0);

        // Reset in the middle of a blocking wait
        request(8'h07, -1, 1'b0, 0);
        @(posedge clk); #1;
        fproc_enable = 1'b1;
        fproc_id = 8'h87;
        meas_valid = '0;
        busy_lo = cyc + 1;
        busy_hi = INF;
        repeat (5) begin
            @(posedge clk); #1;
            fproc_enable = 1'b0;
        end
        reset = 1'b1;
        busy_lo = 1;
        busy_hi = 0;
        hold_data = '0;
        terr_set = INF;
        lat_m = '0;
        fresh_m = '0;
        #1;
        check("midwait_rst_busy", {31'b0, busy}, 32'h0);
        check("midwait_rst_ready", {31'b0, fproc_ready}, 32'h0);
        check("midwait_rst_data", fproc_data, 32'h0);
        check("midwait_rst_terr", {31'b0, timeout_err}, 32'h0);
        check("midwait_rst_pending", exp_q.size(), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        request(8'h03, -1, 1'b0, 0);
        request(8'h83, 3, 1'b1, 0);

        // Randomized traffic with background measurement strobes
        bg_en = 1'b1;
        repeat (150) begin
            chs = ($urandom_range(0, 9) == 0) ? $urandom_range(8, 127) : $urandom_range(0, 7);
            id = {1'($urandom_range(0, 1)), 7'(chs)};
            d = ($urandom_range(0, 3) == 0) ? -1 : $urandom_range(0, TO + 2);
            spur = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 4);
            request(id, d, 1'($urandom_range(0, 1)), spur);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end

        bg_en = 1'b0;
        idle(4);
        check("pending_responses", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fproc_meas_responder.md
Name: fproc_meas_responder

Overview:
- Function-processor responder for the core-side fproc request interface: the other end of a core controller's `fproc_out_ready` / `fproc_ready` handshake.
- Latches per-channel single-bit measurement results from the readout path.
- Answers each core request with a registered data word and a one-cycle ready pulse.
- Supports two request kinds:
  - immediate read: return the last latched value;
  - blocking read: wait for a fresh result, bounded by a timeout.

Parameters:
- N_MEAS, 8, number of measurement channels (1..64).
- ID_WIDTH, 8, width of fproc_id; MSB selects blocking mode, low ID_WIDTH-1 bits select the channel.
- DATA_WIDTH, 32, width of fproc_data.
- TIMEOUT_CYCLES, 1024, maximum wait for a blocking read; must be ≥1.
- CNT_WIDTH, 16, timeout counter width; must satisfy TIMEOUT_CYCLES < 2^CNT_WIDTH.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- fproc_id  in  ID_WIDTH  request id; sampled with fproc_enable
- fproc_enable  in  1  single-cycle request strobe from the core
- fproc_ready  out  1  single-cycle response strobe; fproc_data valid in the same cycle
- fproc_data  out  DATA_WIDTH  response word
- meas  in  N_MEAS  measurement result bit per channel
- meas_valid  in  N_MEAS  per-channel strobe; latches meas[i]
- busy  out  1  high from the cycle after an accepted request until the cycle fproc_ready is high, inclusive
- timeout_err  out  1  sticky; set when any blocking read times out; cleared only by reset

Behaviour:
- Reset is asynchronous and active-high. While asserted, all outputs are 0 immediately, all latched meas bits and fresh flags clear, and the FSM goes to IDLE. A reset mid-wait aborts the request with no ready pulse.
- Channel store: when meas_valid[i]=1 at a posedge, lat[i]<=meas[i] and fresh[i]<=1. A read of channel i that produces a response clears fresh[i].
- If a consuming read of channel i and meas_valid[i] occur in the same cycle, the new value is latched and returned in the response, and fresh[i] ends at 0.
- Response word layout:
  - data[0] = returned meas bit;
  - data[1] = fresh[i] as seen at response time, including a same-cycle valid;
  - data[2] = invalid-channel flag;
  - data[DATA_WIDTH-1] = timeout;
  - all other bits 0.
- fproc_data holds its last value between responses; its reset value is 0.
- FSM states:
  - IDLE: on fproc_enable, capture ch=fproc_id[ID_WIDTH-2:0] and blk=fproc_id[ID_WIDTH-1].
    - ch ≥ N_MEAS → RESPOND with data[2]=1, data[0]=0.
    - blk=0 → RESPOND with lat[ch].
    - blk=1 and (fresh[ch] or meas_valid[ch]) → RESPOND.
    - Otherwise → WAIT, with counter cleared to 0.
  - WAIT: cnt increments each cycle.
    - meas_valid[ch] → RESPOND with the bypassed meas[ch] value.
    - Else cnt==TIMEOUT_CYCLES-1 → RESPOND with data[DATA_WIDTH-1]=1, data[0]=lat[ch], fresh unchanged; timeout_err<=1.
    - A valid arriving on the timeout cycle wins: normal response, no timeout.
  - RESPOND: fproc_ready=1 for exactly one cycle with the registered data, then → IDLE.
- Latency:
  - Immediate, invalid, or already-fresh request: fproc_enable at cycle T gives fproc_ready at T+1.
  - Blocking wait: ready comes 1 cycle after the valid cycle. A timeout gives ready at T+1+TIMEOUT_CYCLES.
- fproc_enable while busy=1 or in RESPOND is ignored; the core has at most one outstanding request.
- A request strobe in the cycle right after ready (FSM back in IDLE) is accepted normally. Back-to-back requests therefore give at most one response per 2 cycles.
- meas_valid on channels other than the waited channel update their stores normally during WAIT.

Test Plan:
- Reset, then meas_valid[3]=1 with meas[3]=1, then request id=0x03 → fproc_ready 1 cycle later, data=0x3 (bit0=1, fresh=1). Repeat the request → data=0x1 (fresh now cleared).
- Blocking request id=0x85 with fresh[5]=0; pulse meas_valid[5] with meas=1 after 10 cycles → ready the cycle after the valid, data=0x3, busy high throughout the wait.
- Blocking request id=0x82 with TIMEOUT_CYCLES=16 and no valid → ready at T+17, data=0x80000000|lat[2], timeout_err=1 and stays 1.
- Request id=0x0A with N_MEAS=8 → ready at T+1, data=0x4. Then a second fproc_enable while busy during a blocking wait → ignored, exactly one ready pulse.
- Same-cycle case: request id=0x01 coincident with meas_valid[1]=1, meas[1]=1 → data=0x3, fresh[1]=0 afterwards. Valid landing exactly on the timeout cycle → normal response, no timeout bit.
- Assert reset mid-WAIT → fproc_ready never pulses, busy=0 immediately. A request after reset behaves as from cold.
